// File: rtl/imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_uart_loader
// Brief    : UART (8N1) boot loader that streams a length-prefixed program
//            into instruction memory, then releases the core.
// Revision : 1.0
// ============================================================================
module imem_uart_loader #(
    parameter int          CLKS_PER_BIT = 434,
    parameter int          MAX_WORDS    = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    output logic [31:0] addr_out,
    output logic [31:0] instr_out,
    output logic        we_out,
    output logic        load_active,
    output logic        cpu_run,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CNT_W-1:0] c_half_m1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] c_full_m1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [31:0]      c_max_words = 32'(MAX_WORDS);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    localparam logic [1:0] L_HDR  = 2'd0;
    localparam logic [1:0] L_WORD = 2'd1;
    localparam logic [1:0] L_DONE = 2'd2;
    localparam logic [1:0] L_ERR  = 2'd3;

    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]       r_rx_state, w_rx_next;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_rx_shift;
    logic             w_fall, w_rx_tick, w_bit_sample, w_byte_valid, w_frame_err;

    logic [1:0]       r_load_state, w_load_next;
    logic [1:0]       r_byte_cnt;
    logic [31:0]      r_asm;
    logic [31:0]      r_num_words;
    logic [31:0]      r_word_cnt;
    logic [31:0]      w_word;
    logic             w_last_byte, w_collect, w_write;
    logic             r_we, r_done;
    logic [31:0]      r_addr, r_instr;

    // ------------------------------------------------------------------ RX
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_fall    = r_rx_prev & ~r_rx_sync;
    // Start bit is checked at its mid-point; every later sample is one bit on.
    assign w_rx_tick = (r_rx_state == R_START) ? (r_clk_cnt == c_half_m1)
                                               : (r_clk_cnt == c_full_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rx_state <= R_IDLE;
        else        r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (w_fall) w_rx_next = R_START;
            R_START: if (w_rx_tick) w_rx_next = r_rx_sync ? R_IDLE : R_DATA;
            R_DATA:  if (w_rx_tick && (r_bit_idx == 3'd7)) w_rx_next = R_STOP;
            R_STOP:  if (w_rx_tick) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        w_bit_sample = (r_rx_state == R_DATA) && w_rx_tick;
        w_byte_valid = (r_rx_state == R_STOP) && w_rx_tick && r_rx_sync;
        w_frame_err  = (r_rx_state == R_STOP) && w_rx_tick && !r_rx_sync;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_cnt  <= '0;
            r_bit_idx  <= 3'd0;
            r_rx_shift <= 8'd0;
        end else begin
            if ((r_rx_state == R_IDLE) || w_rx_tick) r_clk_cnt <= '0;
            else                                     r_clk_cnt <= r_clk_cnt + CNT_W'(1);

            if (r_rx_state != R_DATA) r_bit_idx <= 3'd0;
            else if (w_rx_tick)       r_bit_idx <= r_bit_idx + 3'd1;

            if (w_bit_sample) r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
        end
    end

    // -------------------------------------------------------------- Loader
    // Bytes shift in from the top so the first byte lands in bits 7:0.
    assign w_word      = {r_rx_shift, r_asm[31:8]};
    assign w_collect   = (r_load_state == L_HDR) || (r_load_state == L_WORD);
    assign w_last_byte = w_byte_valid && (r_byte_cnt == 2'd3);
    assign w_write     = (r_load_state == L_WORD) && w_last_byte;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_load_state <= L_HDR;
        else        r_load_state <= w_load_next;
    end

    always_comb begin
        w_load_next = r_load_state;
        case (r_load_state)
            L_HDR: begin
                if (w_frame_err)                 w_load_next = L_ERR;
                else if (w_last_byte) begin
                    if (w_word == 32'd0)         w_load_next = L_DONE;
                    else if (w_word > c_max_words) w_load_next = L_ERR;
                    else                         w_load_next = L_WORD;
                end
            end
            L_WORD: begin
                if (w_frame_err)                 w_load_next = L_ERR;
                // Leave only after the final strobe so done trails it by a cycle.
                else if (r_we && (r_word_cnt == r_num_words)) w_load_next = L_DONE;
            end
            L_DONE:  w_load_next = L_DONE;
            L_ERR:   w_load_next = L_ERR;
            default: w_load_next = L_HDR;
        endcase
    end

    always_comb begin
        load_active = w_collect;
        cpu_run     = (r_load_state == L_DONE);
        err         = (r_load_state == L_ERR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_cnt  <= 2'd0;
            r_asm       <= 32'd0;
            r_num_words <= 32'd0;
            r_word_cnt  <= 32'd0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_addr      <= BASE_ADDR;
            r_instr     <= 32'd0;
        end else begin
            if (w_collect && w_byte_valid) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_asm      <= w_word;
            end
            if ((r_load_state == L_HDR) && w_last_byte) r_num_words <= w_word;

            r_we <= w_write;
            if (w_write) begin
                r_addr     <= BASE_ADDR + (r_word_cnt << 2);
                r_instr    <= w_word;
                r_word_cnt <= r_word_cnt + 32'd1;
            end

            r_done <= (w_load_next == L_DONE) && (r_load_state != L_DONE);
        end
    end

    assign addr_out  = r_addr;
    assign instr_out = r_instr;
    assign we_out    = r_we;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_imem_uart_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_uart_loader
// Brief    : Self-checking bench for imem_uart_loader with a program-level model.
// Revision : 1.0
// ============================================================================
module tb_imem_uart_loader;

    localparam int          CPB  = 4;
    localparam int          MAXW = 8;
    localparam logic [31:0] BASE = 32'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] addr_out, instr_out;
    logic        we_out, load_active, cpu_run, done, err;

    imem_uart_loader #(
        .CLKS_PER_BIT(CPB),
        .MAX_WORDS   (MAXW),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .addr_out   (addr_out),
        .instr_out  (instr_out),
        .we_out     (we_out),
        .load_active(load_active),
        .cpu_run    (cpu_run),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    int          got_done = 0;
    int          we_cyc = 0;
    int          done_cyc = 0;

    always @(negedge clk) begin
        if (we_out) begin
            got_addr.push_back(addr_out);
            got_data.push_back(instr_out);
            we_cyc = cyc;
        end
        if (done) begin
            got_done = got_done + 1;
            done_cyc = cyc;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_done;
    logic        exp_err;

    // Program-level reference: header gives N, then N little-endian words.
    task automatic model_run();
        logic [31:0] n;
        exp_addr.delete();
        exp_data.delete();
        exp_done = 0;
        exp_err  = 1'b0;
        if (tx_q.size() < 4) return;
        n = {tx_q[3], tx_q[2], tx_q[1], tx_q[0]};
        if (n == 0) exp_done = 1;
        else if (n > MAXW) exp_err = 1'b1;
        else begin
            for (int k = 0; k < int'(n); k++) begin
                if (4 + 4 * k + 3 < tx_q.size()) begin
                    exp_addr.push_back(BASE + 32'(4 * k));
                    exp_data.push_back({tx_q[4+4*k+3], tx_q[4+4*k+2], tx_q[4+4*k+1], tx_q[4+4*k]});
                end
            end
            if (exp_addr.size() == int'(n)) exp_done = 1;
        end
    endtask

    task automatic clear_obs();
        got_addr.delete();
        got_data.delete();
        got_done = 0;
    endtask

    task automatic bit_time();
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        bit_time();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bit_time();
        end
        rx = stop;
        bit_time();
        rx = 1'b1;
        bit_time();
    endtask

    task automatic send_stream();
        foreach (tx_q[i]) send_byte(tx_q[i], 1'b1);
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clear_obs();
    endtask

    task automatic push_header(input logic [31:0] n);
        tx_q.delete();
        for (int i = 0; i < 4; i++) tx_q.push_back(n[8*i +: 8]);
    endtask

    task automatic push_random_words(input int n);
        for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic compare_model(input string tag);
        n_checks++;
        if (got_addr.size() !== exp_addr.size())
            $display("FAIL %s write_count got=%0d exp=%0d", tag, got_addr.size(), exp_addr.size());
        else n_pass++;
        for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
            n_checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("FAIL %s write%0d got=%h:%h exp=%h:%h", tag, i,
                         got_addr[i], got_data[i], exp_addr[i], exp_data[i]);
            else n_pass++;
        end
        n_checks++;
        if (got_done !== exp_done || err !== exp_err || cpu_run !== (exp_done == 1))
            $display("FAIL %s status got done=%0d err=%b run=%b exp done=%0d err=%b",
                     tag, got_done, err, cpu_run, exp_done, exp_err);
        else n_pass++;
    endtask

    task automatic test_reset();
        assert_reset();
        n_checks++;
        if (addr_out !== BASE || instr_out !== 32'd0)
            $display("FAIL reset_bus got addr=%h instr=%h exp addr=%h instr=0", addr_out, instr_out, BASE);
        else n_pass++;
        n_checks++;
        if ({we_out, done, err, cpu_run, load_active} !== 5'b00001)
            $display("FAIL reset_ctrl got we/done/err/run/active=%b exp=00001",
                     {we_out, done, err, cpu_run, load_active});
        else n_pass++;
        release_reset();
    endtask

    task automatic test_two_words();
        push_header(32'd2);
        tx_q.push_back(8'h13); tx_q.push_back(8'h05); tx_q.push_back(8'h10); tx_q.push_back(8'h00);
        tx_q.push_back(8'h93); tx_q.push_back(8'h05); tx_q.push_back(8'h20); tx_q.push_back(8'h00);
        send_stream();
        n_checks++;
        if (got_addr.size() !== 2) $display("FAIL two_words count got=%0d exp=2", got_addr.size());
        else n_pass++;
        if (got_addr.size() == 2) begin
            n_checks++;
            if (got_addr[0] !== 32'h100 || got_data[0] !== 32'h00100513)
                $display("FAIL two_words w0 got=%h:%h exp=00000100:00100513", got_addr[0], got_data[0]);
            else n_pass++;
            n_checks++;
            if (got_addr[1] !== 32'h104 || got_data[1] !== 32'h00200593)
                $display("FAIL two_words w1 got=%h:%h exp=00000104:00200593", got_addr[1], got_data[1]);
            else n_pass++;
        end
        n_checks++;
        if (got_done !== 1 || done_cyc !== we_cyc + 1)
            $display("FAIL two_words done got count=%0d at=%0d exp count=1 at=%0d", got_done, done_cyc, we_cyc + 1);
        else n_pass++;
        n_checks++;
        if (cpu_run !== 1'b1 || load_active !== 1'b0 || err !== 1'b0)
            $display("FAIL two_words status got run=%b active=%b err=%b exp 1 0 0", cpu_run, load_active, err);
        else n_pass++;
        tx_q.delete();
        push_random_words(1);
        clear_obs();
        send_stream();
        n_checks++;
        if (got_addr.size() !== 0 || got_done !== 0)
            $display("FAIL after_done got writes=%0d done=%0d exp 0 0", got_addr.size(), got_done);
        else n_pass++;
    endtask

    task automatic test_zero_words();
        assert_reset();
        release_reset();
        push_header(32'd0);
        model_run();
        send_stream();
        compare_model("zero_words");
        n_checks++;
        if (load_active !== 1'b0) $display("FAIL zero_words active got=%b exp=0", load_active);
        else n_pass++;
    endtask

    task automatic test_too_many();
        assert_reset();
        release_reset();
        push_header(32'(MAXW + 1));
        push_random_words(1);
        model_run();
        send_stream();
        compare_model("too_many");
        n_checks++;
        if (load_active !== 1'b0) $display("FAIL too_many active got=%b exp=0", load_active);
        else n_pass++;
    endtask

    task automatic test_framing();
        assert_reset();
        release_reset();
        push_header(32'd1);
        send_stream();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (err !== 1'b1 || cpu_run !== 1'b0 || load_active !== 1'b0)
            $display("FAIL framing status got err=%b run=%b active=%b exp 1 0 0", err, cpu_run, load_active);
        else n_pass++;
        n_checks++;
        if (got_addr.size() !== 0 || got_done !== 0)
            $display("FAIL framing activity got writes=%0d done=%0d exp 0 0", got_addr.size(), got_done);
        else n_pass++;
    endtask

    task automatic test_glitch();
        assert_reset();
        release_reset();
        rx = 1'b0;
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        push_header(32'd1);
        push_random_words(1);
        model_run();
        send_stream();
        compare_model("glitch");
    endtask

    task automatic test_reset_mid();
        assert_reset();
        release_reset();
        push_header(32'd2);
        push_random_words(1);
        void'(tx_q.pop_back());
        void'(tx_q.pop_back());
        void'(tx_q.pop_back());
        send_stream();
        assert_reset();
        n_checks++;
        if ({we_out, done, err, cpu_run, load_active} !== 5'b00001 || addr_out !== BASE || instr_out !== 32'd0)
            $display("FAIL reset_mid outputs got ctrl=%b addr=%h instr=%h exp ctrl=00001 addr=%h instr=0",
                     {we_out, done, err, cpu_run, load_active}, addr_out, instr_out, BASE);
        else n_pass++;
        release_reset();
        push_header(32'd1);
        push_random_words(1);
        model_run();
        send_stream();
        compare_model("reset_mid");
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            assert_reset();
            release_reset();
            push_header(32'($urandom_range(1, MAXW)));
            push_random_words(int'({tx_q[3], tx_q[2], tx_q[1], tx_q[0]}));
            model_run();
            send_stream();
            compare_model("random");
        end
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_zero_words();
        test_too_many();
        test_framing();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_uart_loader.md
IMEM_UART_LOADER -- requirements
Module: imem_uart_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the clk cycles per UART bit (min 4).
REQ-002 Parameter MAX_WORDS, default 1024, SHALL set the largest accepted program length in words.
REQ-003 Parameter BASE_ADDR, default 32'h0, SHALL set the byte address of the first word written.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 rx  input  1  UART serial in, 8N1, LSB first, idle high; asynchronous to clk.
REQ-007 addr_out  output  32  instruction-memory byte address (drives ADDRESS).
REQ-008 instr_out  output  32  instruction word (drives INSTRUCTION).
REQ-009 we_out  output  1  one-cycle instruction-memory write strobe.
REQ-010 load_active  output  1  loader owns imem; drives the address-mux select enable_inst_in.
REQ-011 cpu_run  output  1  level; releases the core after a successful load.
REQ-012 done  output  1  one-cycle pulse when the last word is written.
REQ-013 err  output  1  sticky framing/length error flag.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all decoding uses the synchronized value.
REQ-015 RX FSM states SHALL be R_IDLE, R_START, R_DATA, R_STOP.
REQ-016 R_IDLE -> R_START on a synchronized high-to-low transition.
REQ-017 R_START samples at CLKS_PER_BIT/2: low -> R_DATA; high -> R_IDLE (false start, no byte).
REQ-018 R_DATA samples 8 bits at 1-bit intervals from the start mid-point, LSB first, then enters R_STOP.
REQ-019 R_STOP samples 1 bit later: high -> byte_valid for 1 cycle, then R_IDLE; low -> framing error, then R_IDLE.
REQ-020 Loader FSM states SHALL be L_HDR, L_WORD, L_DONE, L_ERR.
REQ-021 L_HDR collects 4 bytes, little-endian (first byte = bits 7:0), into word count N.
REQ-022 After the 4th header byte: N=0 -> L_DONE; N>MAX_WORDS -> L_ERR; otherwise -> L_WORD.
REQ-023 L_WORD collects 4 bytes, little-endian, per instruction word k (k = 0..N-1).
REQ-024 The cycle after the 4th byte_valid of word k: we_out=1 for exactly one cycle, with instr_out = the word and addr_out = BASE_ADDR + 4*k (mod 2^32).
REQ-025 addr_out and instr_out SHALL hold their values until the next write.
REQ-026 After the write of word N-1 -> L_DONE; done pulses in the cycle after that we_out.
REQ-027 On entry to L_DONE: load_active=0 and cpu_run=1, held until reset; later rx bytes are ignored.
REQ-028 A framing error in L_HDR or L_WORD -> L_ERR: err=1, load_active=0, cpu_run=0, held until reset; partial bytes are discarded; no we_out.
REQ-029 In L_DONE and L_ERR, we_out SHALL never assert.
REQ-030 The byte counter (2 bits) SHALL wrap 3 -> 0 at each word boundary; the word counter SHALL be 32 bits wide.
REQ-031 For N=0, done SHALL pulse the cycle after the header completes, with no write.

Reset
REQ-032 On rst_n low, immediately: addr_out=BASE_ADDR, instr_out=0, we_out=0, done=0, err=0, cpu_run=0, load_active=1; RX FSM = R_IDLE; loader FSM = L_HDR; counters = 0; synchronizer flops = 1.
REQ-033 Reset asserted mid-byte or mid-program SHALL abort the load; the next byte after release is treated as header byte 0.

Verification (CLKS_PER_BIT=4, BASE_ADDR=0x100)
REQ-034 Header 02 00 00 00, then bytes 13 05 10 00 93 05 20 00 -> we_out at 0x100 = 0x00100513 and at 0x104 = 0x00200593; done 1 cycle after the 2nd write; cpu_run=1; load_active=0.
REQ-035 Header 00 00 00 00 -> no we_out; done pulses; cpu_run=1.
REQ-036 Header with N=MAX_WORDS+1 -> err=1, load_active=0, no writes; subsequent bytes produce no activity.
REQ-037 Stop bit driven low during the 2nd byte of word 0 -> err=1, no we_out, cpu_run stays 0.
REQ-038 A 1-cycle low glitch on rx while idle -> no byte is accepted; a following valid header is received correctly.
REQ-039 rst_n pulsed low after 5 bytes of a load -> outputs return to reset values at once; a fresh 1-word load then writes at 0x100.
